// File: rtl/multiplier_if.sv
// Operand/result bundle for the array multiplier.
// Valid-only handshake, no back-pressure: a pair is accepted on every clk edge with
// in_valid high; out_valid marks the following cycle, in which P holds its product.
interface multiplier_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               in_valid;
  logic [2*WIDTH-1:0] P;
  logic               out_valid;

  modport master (
    output A,
    output B,
    output in_valid,
    input  P,
    input  out_valid
  );

  modport slave (
    input  A,
    input  B,
    input  in_valid,
    output P,
    output out_valid
  );
endinterface

// File: rtl/multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier with a one-cycle registered result.
// Partial products are reduced by carry-save adder rows, then a ripple-carry adder.
module multiplier #(
  parameter int WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  multiplier_if.slave   bus
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] pp [WIDTH];
  logic [PW-1:0] row_s;
  logic [PW-1:0] row_c;
  logic [PW-1:0] nxt_s;
  logic [PW-1:0] nxt_c;
  logic [PW-1:0] product;
  logic          rc;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = PW'({WIDTH{bus.B[i]}} & bus.A) << i;
    end

    row_s = pp[0];
    row_c = '0;
    nxt_s = '0;
    nxt_c = '0;
    // Each row folds one partial product into the sum/carry pair; a carry out of the
    // top bit is always zero because the full product fits in PW bits.
    for (int i = 1; i < WIDTH; i++) begin
      nxt_c = '0;
      for (int k = 0; k < PW; k++) begin
        nxt_s[k] = row_s[k] ^ row_c[k] ^ pp[i][k];
      end
      for (int k = 0; k < PW - 1; k++) begin
        nxt_c[k+1] = (row_s[k] & row_c[k]) | (row_s[k] & pp[i][k]) | (row_c[k] & pp[i][k]);
      end
      row_s = nxt_s;
      row_c = nxt_c;
    end

    rc      = 1'b0;
    product = '0;
    for (int k = 0; k < PW; k++) begin
      product[k] = row_s[k] ^ row_c[k] ^ rc;
      rc         = (row_s[k] & row_c[k]) | (row_s[k] & rc) | (row_c[k] & rc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.P         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.P <= product;
      end
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: WIDTH=2 and WIDTH=8 instances stepped together, directed
// cases followed by random pairs, checked against an arithmetic reference model.
module tb_multiplier;
  logic clk;
  logic rst;

  multiplier_if #(.WIDTH(2)) bus2 ();
  multiplier_if #(.WIDTH(8)) bus8 ();

  multiplier #(.WIDTH(2)) u_mul2 (.clk(clk), .rst(rst), .bus(bus2));
  multiplier #(.WIDTH(8)) u_mul8 (.clk(clk), .rst(rst), .bus(bus8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          n_checks;
  int          n_pass;
  logic [3:0]  exp_q2[$];
  logic [15:0] exp_q8[$];
  logic [3:0]  last_p2;
  logic [15:0] last_p8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // one clock: drive both DUTs, advance, then compare against the model
  task automatic step(input int a2, input int b2, input bit v2,
                      input int a8, input int b8, input bit v8, input bit r);
    logic [3:0]  e2;
    logic [15:0] e8;
    bus2.A = 2'(a2); bus2.B = 2'(b2); bus2.in_valid = v2;
    bus8.A = 8'(a8); bus8.B = 8'(b8); bus8.in_valid = v8;
    rst = r;
    if (!r && v2) exp_q2.push_back(4'(a2 * b2));
    if (!r && v8) exp_q8.push_back(16'(a8 * b8));
    @(posedge clk);
    #1;
    if (r) begin
      last_p2 = '0;
      last_p8 = '0;
    end
    if (exp_q2.size() > 0) begin
      e2 = exp_q2.pop_front();
      last_p2 = e2;
    end
    if (exp_q8.size() > 0) begin
      e8 = exp_q8.pop_front();
      last_p8 = e8;
    end
    check("w2_out_valid", 32'(bus2.out_valid), 32'(!r && v2));
    check("w2_p", 32'(bus2.P), 32'(last_p2));
    check("w8_out_valid", 32'(bus8.out_valid), 32'(!r && v8));
    check("w8_p", 32'(bus8.P), 32'(last_p8));
  endtask

  // driver: linear directed sequence, then random pairs
  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_p2  = '0;
    last_p8  = '0;
    rst = 1'b1;
    bus2.A = '0; bus2.B = '0; bus2.in_valid = 1'b0;
    bus8.A = '0; bus8.B = '0; bus8.in_valid = 1'b0;

    // reset with valid pairs present: discarded, outputs zero
    step(3, 3, 1, 200, 7, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // (3,1) -> 3
    step(3, 1, 1, 0, 0, 0, 0);
    // back-to-back 9,2,6,4
    step(3, 3, 1, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    step(2, 3, 1, 0, 0, 0, 0);
    step(2, 2, 1, 0, 0, 0, 0);

    // exhaustive WIDTH=2 sweep alongside WIDTH=8 corners
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        step(a, b, 1, a * 85, b * 85, 1, 0);
      end
    end
    step(0, 0, 0, 255, 255, 1, 0);
    step(0, 0, 0, 128, 2, 1, 0);
    step(0, 0, 0, 0, 255, 1, 0);
    step(0, 0, 0, 255, 0, 1, 0);

    // hold after P=6
    step(2, 3, 1, 17, 3, 1, 0);
    step(1, 1, 0, 9, 9, 0, 0);
    step(3, 3, 0, 1, 1, 0, 0);
    step(1, 3, 1, 2, 5, 1, 0);

    // reset mid-stream while (3,2) is launched, then (3,1)
    step(3, 2, 1, 100, 3, 1, 1);
    step(3, 1, 1, 12, 12, 1, 0);

    // repeated pair gives repeated results
    step(3, 2, 1, 77, 33, 1, 0);
    step(3, 2, 1, 77, 33, 1, 0);

    // random pairs with random valid and rare resets
    for (int n = 0; n < 150; n++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    end
    step(0, 0, 0, 0, 0, 0, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
